piso_shift_tx: RTL and testbench

//   Parallel-in / serial-out transmitter for the 8-bit serial shift link.

---
 rtl/piso_shift_tx.sv | 109 ++++++++++
 tb/tb_piso_shift_tx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in / serial-out transmitter for the serial shift link.
// A word is accepted over a valid/ready handshake and sent one bit per clock,
// MSB or LSB first, with sof/done framing. Back-to-back words are sent without
// gaps because a new word can be loaded on the same edge that retires the last bit.
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             d_out,
    output logic             d_valid,
    output logic             sof,
    output logic             done,
    output logic             busy
);

    localparam int             CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_sreg_nxt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_bit_cnt_nxt;
    logic             w_shifting;
    logic             w_last;
    logic             w_xfer;

    assign w_shifting = (r_state == ST_SHIFT);
    assign w_last     = w_shifting && (r_bit_cnt == LAST_CNT);

    // Ready while idle, or on the last bit so the next word follows gaplessly.
    // It deliberately never looks at in_valid.
    assign in_ready = (r_state == ST_IDLE) || w_last;
    assign w_xfer   = in_valid && in_ready;

    // Outputs are decoded from registered state only; no input reaches them.
    assign d_valid = w_shifting;
    assign busy    = w_shifting;
    assign sof     = w_shifting && (r_bit_cnt == '0);
    assign done    = w_last;
    assign d_out   = w_shifting && (MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0]);

    // Next-state, shift-register and bit-counter decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        w_state_nxt   = r_state;
        w_sreg_nxt    = r_sreg;
        w_bit_cnt_nxt = r_bit_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt   = ST_SHIFT;
                    w_sreg_nxt    = in_data;
                    w_bit_cnt_nxt = '0;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    if (w_xfer) begin
                        w_sreg_nxt    = in_data;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_state_nxt   = ST_IDLE;
                        w_sreg_nxt    = '0;
                        w_bit_cnt_nxt = '0;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    if (MSB_FIRST) begin
                        w_sreg_nxt = {r_sreg[WIDTH-2:0], 1'b0};
                    end else begin
                        w_sreg_nxt = {1'b0, r_sreg[WIDTH-1:1]};
                    end
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_sreg_nxt    = '0;
                w_bit_cnt_nxt = '0;
            end
        endcase
    end

    // State, shift register and counter; reset aborts any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_sreg    <= '0;
            r_bit_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
            r_state   <= w_state_nxt;
            r_sreg    <= w_sreg_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed testbench for piso_shift_tx: one MSB-first and one LSB-first instance.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_piso_shift_tx;

    logic       clk;
    logic       rst_n;

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready, m_dout, m_dvalid, m_sof, m_done, m_busy;

    logic [7:0] l_data;
    logic       l_valid;
    logic       l_ready, l_dout, l_dvalid, l_sof, l_done, l_busy;

    int n_checks;
    int n_fail;

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (m_data),
        .in_valid (m_valid),
        .in_ready (m_ready),
        .d_out    (m_dout),
        .d_valid  (m_dvalid),
        .sof      (m_sof),
        .done     (m_done),
        .busy     (m_busy)
    );

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (l_data),
        .in_valid (l_valid),
        .in_ready (l_ready),
        .d_out    (l_dout),
        .d_valid  (l_dvalid),
        .sof      (l_sof),
        .done     (l_done),
        .busy     (l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reset state of both instances, then in_ready after release.
    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if ({m_dout, m_dvalid, m_sof, m_done, m_busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_msb_outputs: got %b expected 00000", {m_dout, m_dvalid, m_sof, m_done, m_busy});
        end
        n_checks++;
        if ({l_dout, l_dvalid, l_sof, l_done, l_busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_lsb_outputs: got %b expected 00000", {l_dout, l_dvalid, l_sof, l_done, l_busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        n_checks++;
        if ({m_ready, l_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 11", {m_ready, l_ready});
        end
    endtask

    // One word 8'h96 MSB-first, with a shift-left receiver model on the bench side.
    task automatic test_single_word();
        logic [7:0] pat;
        logic [7:0] rx;
        pat = 8'h96;
        rx  = 8'h00;
        m_data  = pat;
        m_valid = 1'b1;
        n_checks++;
        if (m_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_idle_ready: got %b expected 1", m_ready);
        end
        next_cycle();
        m_valid = 1'b0;
        m_data  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({m_dvalid, m_busy, m_dout, m_sof, m_done} !== {1'b1, 1'b1, pat[7-i], (i == 0), (i == 7)}) begin
                n_fail++;
                $display("FAIL single_bit%0d: got v/b/d/sof/done=%b expected %b", i,
                         {m_dvalid, m_busy, m_dout, m_sof, m_done}, {1'b1, 1'b1, pat[7-i], (i == 0), (i == 7)});
            end
            if (m_dvalid) rx = {rx[6:0], m_dout};
            next_cycle();
        end
        n_checks++;
        if ({m_dvalid, m_dout, m_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL single_idle_after: got v/d/ready=%b expected 001", {m_dvalid, m_dout, m_ready});
        end
        n_checks++;
        if (rx !== 8'h96) begin
            n_fail++;
            $display("FAIL single_rx_word: got %h expected 96", rx);
        end
    endtask

    // 8'hA5 then 8'h3C with in_valid held: 16 gapless bits.
    task automatic test_back_to_back();
        logic [15:0] stream;
        stream  = 16'hA53C;
        m_data  = 8'hA5;
        m_valid = 1'b1;
        next_cycle();
        m_data = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) m_valid = 1'b0;
            n_checks++;
            if ({m_dvalid, m_dout, m_sof, m_done, m_ready} !==
                {1'b1, stream[15-i], (i % 8 == 0), (i % 8 == 7), (i % 8 == 7)}) begin
                n_fail++;
                $display("FAIL b2b_bit%0d: got v/d/sof/done/rdy=%b expected %b", i,
                         {m_dvalid, m_dout, m_sof, m_done, m_ready},
                         {1'b1, stream[15-i], (i % 8 == 0), (i % 8 == 7), (i % 8 == 7)});
            end
            next_cycle();
        end
        n_checks++;
        if (m_dvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_after: got d_valid=%b expected 0", m_dvalid);
        end
    endtask

    // 8'hFF offered during bit 3 of 8'h00 must wait until the last bit.
    task automatic test_backpressure();
        int ones;
        ones    = 0;
        m_data  = 8'h00;
        m_valid = 1'b1;
        next_cycle();
        m_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 2) begin
                m_valid = 1'b1;
                m_data  = 8'hFF;
            end
            if (i == 8) m_valid = 1'b0;
            n_checks++;
            if ({m_dvalid, m_dout, m_sof, m_ready} !== {1'b1, (i >= 8), (i == 0 || i == 8), (i == 7 || i == 15)}) begin
                n_fail++;
                $display("FAIL bp_bit%0d: got v/d/sof/rdy=%b expected %b", i,
                         {m_dvalid, m_dout, m_sof, m_ready}, {1'b1, (i >= 8), (i == 0 || i == 8), (i == 7 || i == 15)});
            end
            if (m_dvalid && m_dout) ones++;
            next_cycle();
        end
        n_checks++;
        if (m_dvalid !== 1'b0 || ones != 8) begin
            n_fail++;
            $display("FAIL bp_ones: got d_valid=%b ones=%0d expected d_valid=0 ones=8", m_dvalid, ones);
        end
    endtask

    // Asynchronous reset at bit 4 of 8'hF0, then a clean 8'h81.
    task automatic test_reset_mid_word();
        logic [7:0] pat;
        pat     = 8'h81;
        m_data  = 8'hF0;
        m_valid = 1'b1;
        next_cycle();
        m_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({m_dvalid, m_dout} !== 2'b11) begin
                n_fail++;
                $display("FAIL rmw_pre_bit%0d: got v/d=%b expected 11", i, {m_dvalid, m_dout});
            end
            next_cycle();
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({m_dout, m_dvalid, m_sof, m_done, m_busy, m_ready} !== 6'b000001) begin
            n_fail++;
            $display("FAIL rmw_async: got d/v/sof/done/busy/rdy=%b expected 000001",
                     {m_dout, m_dvalid, m_sof, m_done, m_busy, m_ready});
        end
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if ({m_dvalid, m_done} !== 2'b00) begin
                n_fail++;
                $display("FAIL rmw_held: got v/done=%b expected 00", {m_dvalid, m_done});
            end
        end
        rst_n = 1'b1;
        next_cycle();
        n_checks++;
        if ({m_dvalid, m_done, m_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL rmw_release: got v/done/rdy=%b expected 001", {m_dvalid, m_done, m_ready});
        end
        m_data  = pat;
        m_valid = 1'b1;
        next_cycle();
        m_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({m_dvalid, m_dout, m_sof, m_done} !== {1'b1, pat[7-i], (i == 0), (i == 7)}) begin
                n_fail++;
                $display("FAIL rmw_next_bit%0d: got v/d/sof/done=%b expected %b", i,
                         {m_dvalid, m_dout, m_sof, m_done}, {1'b1, pat[7-i], (i == 0), (i == 7)});
            end
            next_cycle();
        end
        n_checks++;
        if (m_dvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rmw_idle_after: got d_valid=%b expected 0", m_dvalid);
        end
    endtask

    // LSB-first instance: 8'h01 -> 1,0,0,0,0,0,0,0 and 8'hB2 -> 0,1,0,0,1,1,0,1.
    task automatic test_lsb_first();
        logic [7:0] words [2];
        logic [7:0] pat;
        words[0] = 8'h01;
        words[1] = 8'hB2;
        for (int w = 0; w < 2; w++) begin
            pat     = words[w];
            l_data  = pat;
            l_valid = 1'b1;
            next_cycle();
            l_valid = 1'b0;
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if ({l_dvalid, l_dout, l_sof, l_done} !== {1'b1, pat[i], (i == 0), (i == 7)}) begin
                    n_fail++;
                    $display("FAIL lsb_w%0d_bit%0d: got v/d/sof/done=%b expected %b", w, i,
                             {l_dvalid, l_dout, l_sof, l_done}, {1'b1, pat[i], (i == 0), (i == 7)});
                end
                next_cycle();
            end
            n_checks++;
            if ({l_dvalid, l_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL lsb_w%0d_idle: got v/rdy=%b expected 01", w, {l_dvalid, l_ready});
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        m_data   = 8'h00;
        m_valid  = 1'b0;
        l_data   = 8'h00;
        l_valid  = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_lsb_first();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
